// File: rtl/proc_multicycle.sv
// Multi-cycle 8-opcode processor core with N/Z/C flags and conditional branches,
// fetching from and storing to one synchronous-read unified memory.
module proc_multicycle #(
    parameter int unsigned W        = 16,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Run,
    input  logic [W-1:0]      mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [W-1:0]      mem_wdata,
    output logic              mem_we,
    output logic              Done,
    output logic [2:0]        flags
);

    localparam logic [W-1:0] ResetPc = W'(RESET_PC);

    localparam logic [2:0] OpMv  = 3'b000;
    localparam logic [2:0] OpMvt = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpLd  = 3'b100;
    localparam logic [2:0] OpSt  = 3'b101;
    localparam logic [2:0] OpAnd = 3'b110;
    localparam logic [2:0] OpB   = 3'b111;

    typedef enum logic [1:0] {StFetch, StDecode, StEx1, StEx2} state_e;

    state_e       state_q, state_d;
    // Entry 7 is the PC, so reads of r7 naturally see the incremented value.
    logic [W-1:0] regs_q [8];
    logic [W-1:0] regs_d [8];
    logic [W-1:0] ir_q, ir_d;
    logic [W-1:0] g_q, g_d;
    logic [2:0]   flags_q, flags_d;

    logic [2:0]   op, rx, ry;
    logic         imm_sel;
    logic [W-1:0] imm, operand, rx_val, mvt_val;
    logic [W-1:0] alu_res;
    logic         alu_c;
    logic [W:0]   sum;
    logic         take;

    assign op      = ir_q[W-1:W-3];
    assign imm_sel = ir_q[W-4];
    assign rx      = ir_q[W-5:W-7];
    assign ry      = ir_q[2:0];
    assign imm     = {{7{ir_q[W-8]}}, ir_q[W-8:0]};
    assign operand = imm_sel ? imm : regs_q[ry];
    assign rx_val  = regs_q[rx];
    assign mvt_val = {ir_q[7:0], {(W-8){1'b0}}};
    assign flags   = flags_q;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        sum     = {1'b0, rx_val} + {1'b0, operand};
        case (op)
            OpAdd: begin
                alu_res = sum[W-1:0];
                alu_c   = sum[W];
            end
            OpSub: begin
                alu_res = rx_val - operand;
                alu_c   = (rx_val >= operand);
            end
            OpAnd:   alu_res = rx_val & operand;
            default: ;
        endcase
    end

    // Branch condition is selected by the rX field, evaluated on {N,Z,C}.
    always_comb begin
        case (rx)
            3'd0:    take = 1'b1;
            3'd1:    take = flags_q[1];
            3'd2:    take = ~flags_q[1];
            3'd3:    take = ~flags_q[0];
            3'd4:    take = flags_q[0];
            3'd5:    take = ~flags_q[2];
            3'd6:    take = flags_q[2];
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        ir_d      = ir_q;
        g_d       = g_q;
        flags_d   = flags_q;
        mem_addr  = regs_q[7][ADDR_W-1:0];
        mem_wdata = '0;
        mem_we    = 1'b0;
        Done      = 1'b0;
        unique case (state_q)
            StFetch: begin
                if (Run) begin
                    regs_d[7] = regs_q[7] + W'(1);
                    state_d   = StDecode;
                end
            end
            StDecode: begin
                ir_d    = mem_rdata;
                state_d = StEx1;
            end
            StEx1: begin
                unique case (op)
                    OpMv: begin
                        regs_d[rx] = operand;
                        Done       = 1'b1;
                        state_d    = StFetch;
                    end
                    OpMvt: begin
                        regs_d[rx] = mvt_val;
                        Done       = 1'b1;
                        state_d    = StFetch;
                    end
                    OpAdd, OpSub, OpAnd: begin
                        g_d     = alu_res;
                        flags_d = {alu_res[W-1], alu_res == '0, alu_c};
                        state_d = StEx2;
                    end
                    OpLd: begin
                        mem_addr = regs_q[ry][ADDR_W-1:0];
                        state_d  = StEx2;
                    end
                    OpSt: begin
                        mem_addr  = regs_q[ry][ADDR_W-1:0];
                        mem_wdata = rx_val;
                        mem_we    = 1'b1;
                        Done      = 1'b1;
                        state_d   = StFetch;
                    end
                    OpB: begin
                        if (take) begin
                            regs_d[7] = regs_q[7] + imm;
                        end
                        Done    = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StEx2: begin
                regs_d[rx] = (op == OpLd) ? mem_rdata : g_q;
                Done       = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= StFetch;
            for (int i = 0; i < 7; i++) begin
                regs_q[i] <= '0;
            end
            regs_q[7] <= ResetPc;
            ir_q      <= '0;
            g_q       <= '0;
            flags_q   <= '0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            ir_q    <= ir_d;
            g_q     <= g_d;
            flags_q <= flags_d;
        end
    end

endmodule
